// File: rtl/branch_redirect_ctrl_if.sv
// Execute-stage branch-resolution bundle between the pipeline and
// branch_redirect_ctrl. The pipeline side is the master and the controller
// is the slave.
`timescale 1ns/1ps

interface branch_redirect_ctrl_if #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 ex_valid;
  logic [2:0]           br_type;
  logic                 br_taken;
  logic [BUS_WIDTH-1:0] br_target;
  logic                 mem_busy;
  logic                 pc_sel;
  logic [BUS_WIDTH-1:0] pc_target;
  logic                 flush_ex;
  logic                 stall;
  logic [CNT_WIDTH-1:0] br_cnt;
  logic [CNT_WIDTH-1:0] taken_cnt;

  modport master (
    output ex_valid, br_type, br_taken, br_target, mem_busy,
    input  pc_sel, pc_target, flush_ex, stall, br_cnt, taken_cnt
  );

  modport slave (
    input  ex_valid, br_type, br_taken, br_target, mem_busy,
    output pc_sel, pc_target, flush_ex, stall, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns a resolved taken branch in execute into a
// one-cycle-late PC redirect with two flushed slots, deferring the redirect
// while the memory/UART stage holds the pipeline.
// Optional feature: define BR_STATS_EN to build saturating counters of
// conditional branches and taken branches; otherwise the count ports are 0.
`timescale 1ns/1ps

module branch_redirect_ctrl #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  localparam logic [2:0] BR_NO_JUMP = 3'd2;
  localparam logic [2:0] BR_JUMP    = 3'd3;

  state_t               state_q;
  state_t               state_d;
  logic                 take;
  logic                 latch_target;
  logic                 pc_sel_c;
  logic                 flush_ex_c;
  logic [BUS_WIDTH-1:0] pc_target_q;

  // A taken branch only matters in RUN; in the other states execute holds a
  // flushed bubble or is frozen behind the memory hold.
  assign take = bus.ex_valid & bus.br_taken;

  // State register.
  // NOTE: reset is asynchronous active-low, so rst_n sits in the sensitivity
  // list and every flop is cleared the moment it falls, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge values; blocking (=) here would create ordering races.
      state_q <= state_d;
    end
  end

  // Next-state and redirect/flush decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    pc_sel_c     = 1'b0;
    flush_ex_c   = 1'b0;
    latch_target = 1'b0;
    unique case (state_q)
      RUN: begin
        if (take) begin
          latch_target = 1'b1;
          if (!bus.mem_busy) begin
            flush_ex_c = 1'b1;
            state_d    = REDIRECT;
          end else begin
            state_d    = WAIT_MEM;
          end
        end
      end
      REDIRECT: begin
        if (!bus.mem_busy) begin
          pc_sel_c   = 1'b1;
          flush_ex_c = 1'b1;
          state_d    = RUN;
        end else begin
          state_d    = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (!bus.mem_busy) begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Redirect target: captured only when a branch is accepted in RUN, so a
  // pending redirect can never be overwritten by a later branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_target_q <= '0;
    end else if (latch_target) begin
      pc_target_q <= bus.br_target;
    end
  end

  // While rst_n is low the decode still sees state RUN and could flag a take,
  // so the control outputs are gated to stay quiet throughout reset.
  assign bus.pc_sel    = pc_sel_c & rst_n;
  assign bus.flush_ex  = flush_ex_c & rst_n;
  assign bus.stall     = bus.mem_busy;
  assign bus.pc_target = pc_target_q;

`ifdef BR_STATS_EN
  logic                 cond_br;
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] taken_cnt_q;

  // A conditional branch counts once, in the RUN cycle where it moves on.
  assign cond_br = (state_q == RUN) & bus.ex_valid & !bus.mem_busy &
                   (bus.br_type != BR_NO_JUMP) & (bus.br_type != BR_JUMP);

  // Saturating branch statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (cond_br) begin
      if (br_cnt_q != '1) begin
        br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
      end
      if (bus.br_taken && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
`else
  // Statistics disabled: the ports stay but carry constant zero, and the
  // branch type has no other consumer.
  logic unused_br_type;
  assign unused_br_type = ^bus.br_type;
  assign bus.br_cnt     = '0;
  assign bus.taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl. Each cycle's inputs are applied
// just after the rising edge and outputs are sampled on the falling edge.
// Counter expectations follow BR_STATS_EN; counters are 4 bits wide here so
// saturation is reachable.
`timescale 1ns/1ps

module tb_branch_redirect_ctrl;

  localparam int BW = 32;
  localparam int CW = 4;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic          ev;
    logic [2:0]    ty;
    logic          tk;
    logic [BW-1:0] tg;
    logic          busy;
    logic [2:0]    ctl;   // {pc_sel, flush_ex, stall}
    logic          ct;    // compare pc_target this cycle
    logic [BW-1:0] tgt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_redirect_ctrl_if #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) br_if ();

  branch_redirect_ctrl #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (br_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic ev, logic [2:0] ty, logic tk, logic [BW-1:0] tg,
                             logic busy, logic [2:0] ctl, logic ct, logic [BW-1:0] tgt);
    vec_t r;
    r.ev = ev; r.ty = ty; r.tk = tk; r.tg = tg; r.busy = busy;
    r.ctl = ctl; r.ct = ct; r.tgt = tgt;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    br_if.ex_valid  = x.ev;
    br_if.br_type   = x.ty;
    br_if.br_taken  = x.tk;
    br_if.br_target = x.tg;
    br_if.mem_busy  = x.busy;
  endtask

  task automatic idle();
    br_if.ex_valid  = 1'b0;
    br_if.br_type   = 3'd2;
    br_if.br_taken  = 1'b0;
    br_if.br_target = '0;
    br_if.mem_busy  = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reset state, then reset in the middle of WAIT_MEM discards the redirect.
  task automatic test_reset();
    vec_t q[$];
    rst_n = 1'b0;
    drive(v(1, 3'd0, 1, 32'h0000_0abc, 0, 3'b000, 0, 0));
    #2;
    n_cmp++;
    if ({br_if.pc_sel, br_if.flush_ex, br_if.stall, br_if.pc_target} !== {3'b000, 32'h0}) begin
      n_err++;
      $display("FAIL reset_hold: ctl/pc_target got %b/%h expected 000/00000000",
               {br_if.pc_sel, br_if.flush_ex, br_if.stall}, br_if.pc_target);
    end
    n_cmp++;
    if ({br_if.br_cnt, br_if.taken_cnt} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_cnt: br_cnt/taken_cnt got %0d/%0d expected 0/0",
               br_if.br_cnt, br_if.taken_cnt);
    end
    apply_reset();
    // Taken branch to 0x40 under a memory hold parks the controller in WAIT_MEM.
    q.push_back(v(1, 3'd0, 1, 32'h40, 1, 3'b001, 1, 32'h0));
    q.push_back(v(0, 3'd2, 0, 32'h0,  1, 3'b001, 1, 32'h40));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== q[i].ctl) begin
        n_err++;
        $display("FAIL reset_pre ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, q[i].ctl);
      end
      if (q[i].ct) begin
        n_cmp++;
        if (br_if.pc_target !== q[i].tgt) begin
          n_err++;
          $display("FAIL reset_pre pc_target cycle %0d: got %h expected %h", i, br_if.pc_target, q[i].tgt);
        end
      end
      if (i != q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({br_if.pc_sel, br_if.flush_ex, br_if.pc_target} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL reset_async: pc_sel/flush_ex/pc_target got %b%b/%h expected 00/00000000",
               br_if.pc_sel, br_if.flush_ex, br_if.pc_target);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall, br_if.pc_target} !== {3'b000, 32'h0}) begin
        n_err++;
        $display("FAIL reset_post cycle %0d: ctl/pc_target got %b/%h expected 000/00000000", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, br_if.pc_target);
      end
      @(posedge clk); #1;
    end
  endtask

  // Taken beq with no memory hold: flush at N and N+1, redirect at N+1 only.
  task automatic test_taken_beq();
    vec_t q[$];
    apply_reset();
    q.push_back(v(1, 3'd0, 1, 32'h100, 0, 3'b010, 1, 32'h0));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b110, 1, 32'h100));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h100));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 0, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== q[i].ctl) begin
        n_err++;
        $display("FAIL taken_beq ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, q[i].ctl);
      end
      if (q[i].ct) begin
        n_cmp++;
        if (br_if.pc_target !== q[i].tgt) begin
          n_err++;
          $display("FAIL taken_beq pc_target cycle %0d: got %h expected %h", i, br_if.pc_target, q[i].tgt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Five not-taken conditional branches: no redirect, five counted.
  task automatic test_not_taken();
    logic [CW-1:0] exp_br;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(v(1, 3'd1, 0, 32'h500 + 32'(i), 0, 3'b000, 0, 32'h0));
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall, br_if.pc_target} !== {3'b000, 32'h0}) begin
        n_err++;
        $display("FAIL not_taken cycle %0d: ctl/pc_target got %b/%h expected 000/00000000", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, br_if.pc_target);
      end
      @(posedge clk); #1;
    end
    idle();
    exp_br = STATS ? CW'(5) : CW'(0);
    n_cmp++;
    if ({br_if.br_cnt, br_if.taken_cnt} !== {exp_br, CW'(0)}) begin
      n_err++;
      $display("FAIL not_taken counts: br_cnt/taken_cnt got %0d/%0d expected %0d/0",
               br_if.br_cnt, br_if.taken_cnt, exp_br);
    end
  endtask

  // Branch resolved while memory holds for 3 cycles; redirect one cycle
  // after the hold drops. Frozen/ignored execute branches must not re-latch.
  task automatic test_collision();
    vec_t q[$];
    apply_reset();
    q.push_back(v(1, 3'd0, 1, 32'h200, 1, 3'b001, 1, 32'h0));
    q.push_back(v(1, 3'd0, 1, 32'h200, 1, 3'b001, 1, 32'h200));
    q.push_back(v(1, 3'd0, 1, 32'h200, 1, 3'b001, 1, 32'h200));
    q.push_back(v(1, 3'd0, 1, 32'h999, 0, 3'b000, 1, 32'h200));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b110, 1, 32'h200));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h200));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== q[i].ctl) begin
        n_err++;
        $display("FAIL collision ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, q[i].ctl);
      end
      if (q[i].ct) begin
        n_cmp++;
        if (br_if.pc_target !== q[i].tgt) begin
          n_err++;
          $display("FAIL collision pc_target cycle %0d: got %h expected %h", i, br_if.pc_target, q[i].tgt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Hold arrives in the REDIRECT cycle: redirect deferred, target kept.
  task automatic test_redirect_busy();
    vec_t q[$];
    apply_reset();
    q.push_back(v(1, 3'd0, 1, 32'h80,  0, 3'b010, 1, 32'h0));
    q.push_back(v(0, 3'd2, 0, 32'h0,   1, 3'b001, 1, 32'h80));
    q.push_back(v(1, 3'd0, 1, 32'hf00, 1, 3'b001, 1, 32'h80));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h80));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b110, 1, 32'h80));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h80));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== q[i].ctl) begin
        n_err++;
        $display("FAIL redirect_busy ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, q[i].ctl);
      end
      if (q[i].ct) begin
        n_cmp++;
        if (br_if.pc_target !== q[i].tgt) begin
          n_err++;
          $display("FAIL redirect_busy pc_target cycle %0d: got %h expected %h", i, br_if.pc_target, q[i].tgt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Taken held over two cycles: only the first target redirects. A jump and
  // a no_jump afterwards are not counted as conditional branches.
  task automatic test_back_to_back();
    vec_t q[$];
    logic [CW-1:0] exp_c;
    apply_reset();
    q.push_back(v(1, 3'd0, 1, 32'h100, 0, 3'b010, 1, 32'h0));
    q.push_back(v(1, 3'd0, 1, 32'h300, 0, 3'b110, 1, 32'h100));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h100));
    q.push_back(v(1, 3'd3, 1, 32'h340, 0, 3'b010, 1, 32'h100));
    q.push_back(v(0, 3'd2, 0, 32'h0,   0, 3'b110, 1, 32'h340));
    q.push_back(v(1, 3'd2, 0, 32'h0,   0, 3'b000, 1, 32'h340));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== q[i].ctl) begin
        n_err++;
        $display("FAIL back_to_back ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, q[i].ctl);
      end
      if (q[i].ct) begin
        n_cmp++;
        if (br_if.pc_target !== q[i].tgt) begin
          n_err++;
          $display("FAIL back_to_back pc_target cycle %0d: got %h expected %h", i, br_if.pc_target, q[i].tgt);
        end
      end
      @(posedge clk); #1;
    end
    idle();
    exp_c = STATS ? CW'(1) : CW'(0);
    n_cmp++;
    if ({br_if.br_cnt, br_if.taken_cnt} !== {exp_c, exp_c}) begin
      n_err++;
      $display("FAIL back_to_back counts: br_cnt/taken_cnt got %0d/%0d expected %0d/%0d",
               br_if.br_cnt, br_if.taken_cnt, exp_c, exp_c);
    end
  endtask

  // Twenty taken conditional branches back to back (each takes a RUN and a
  // REDIRECT cycle); 4-bit counters must stop at 15.
  task automatic test_saturation();
    logic [2:0]    exp_ctl;
    logic [CW-1:0] exp_c;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      drive(v(1, 3'd0, 1, 32'h1000 + 32'(i * 4), 0, 3'b000, 0, 32'h0));
      exp_ctl = (i % 2 == 0) ? 3'b010 : 3'b110;
      @(negedge clk);
      n_cmp++;
      if ({br_if.pc_sel, br_if.flush_ex, br_if.stall} !== exp_ctl) begin
        n_err++;
        $display("FAIL saturation ctl cycle %0d: got %b expected %b", i,
                 {br_if.pc_sel, br_if.flush_ex, br_if.stall}, exp_ctl);
      end
      if (i % 2 == 1) begin
        n_cmp++;
        if (br_if.pc_target !== 32'h1000 + 32'((i - 1) * 4)) begin
          n_err++;
          $display("FAIL saturation pc_target cycle %0d: got %h expected %h", i,
                   br_if.pc_target, 32'h1000 + 32'((i - 1) * 4));
        end
      end
      @(posedge clk); #1;
    end
    idle();
    exp_c = STATS ? CW'(15) : CW'(0);
    n_cmp++;
    if ({br_if.br_cnt, br_if.taken_cnt} !== {exp_c, exp_c}) begin
      n_err++;
      $display("FAIL saturation counts: br_cnt/taken_cnt got %0d/%0d expected %0d/%0d",
               br_if.br_cnt, br_if.taken_cnt, exp_c, exp_c);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_taken_beq();
    test_not_taken();
    test_collision();
    test_redirect_busy();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, default 32, datapath/PC width.
REQ-002 Parameter CNT_WIDTH, default 16, statistics counter width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port ex_valid  input  1  execute stage holds a live (non-bubble) instruction.
REQ-006 Port br_type  input  3  branch type of execute-stage instruction; 2 = no_jump, 3 = jump, others conditional.
REQ-007 Port br_taken  input  1  branch-condition result for execute-stage instruction.
REQ-008 Port br_target  input  BUS_WIDTH  resolved target address.
REQ-009 Port mem_busy  input  1  memory/UART stage requests a pipeline hold.
REQ-010 Port pc_sel  output  1  PC loads pc_target instead of PC+4.
REQ-011 Port pc_target  output  BUS_WIDTH  registered redirect address.
REQ-012 Port flush_ex  output  1  replace instruction entering execute with a bubble.
REQ-013 Port stall  output  1  hold PC and fetch/execute pipeline register.
REQ-014 Port br_cnt, taken_cnt  output  CNT_WIDTH each  conditional-branch and taken-branch counts.

Function
REQ-015 FSM states SHALL be RUN, REDIRECT, WAIT_MEM.
REQ-016 take = ex_valid & br_taken, evaluated only in RUN; ignored in REDIRECT and WAIT_MEM (execute stage holds a flushed bubble or is frozen).
REQ-017 stall SHALL equal mem_busy combinationally in every state.
REQ-018 RUN, take, !mem_busy: flush_ex=1 same cycle; latch br_target into pc_target; next state REDIRECT.
REQ-019 RUN, take, mem_busy: flush_ex=0; latch br_target; next state WAIT_MEM (redirect pending).
REQ-020 RUN, no take: pc_sel=0, flush_ex=0; stay RUN.
REQ-021 REDIRECT, !mem_busy: pc_sel=1, flush_ex=1; next state RUN; redirect latency = 1 cycle after resolve, exactly 2 flushed slots total.
REQ-022 REDIRECT, mem_busy: pc_sel=0, flush_ex=0; pc_target held; next state WAIT_MEM.
REQ-023 WAIT_MEM: pc_sel=0, flush_ex=0; pc_target held; next state REDIRECT on first cycle mem_busy=0.
REQ-024 pc_target SHALL change only on a latch event per REQ-018/019; a pending redirect is never lost or overwritten.
REQ-025 pc_sel and flush_ex SHALL never assert while stall=1.

Reset
REQ-026 rst_n low SHALL immediately force state RUN, pc_target=0, br_cnt=0, taken_cnt=0; pc_sel=0, flush_ex=0.
REQ-027 Reset mid-redirect or mid-WAIT_MEM SHALL discard the pending redirect.

Configuration
REQ-028 Macro BR_STATS_EN defined: br_cnt increments on each RUN-state cycle with ex_valid=1, br_type not 2/3, mem_busy=0; taken_cnt increments when that cycle also has br_taken=1; both saturate at all-ones.
REQ-029 BR_STATS_EN undefined: br_cnt and taken_cnt ports remain, tied to 0, no counter flops.

Verification
REQ-030 Reset: rst_n=0 during WAIT_MEM with pc_target=0x40 -> outputs 0, state RUN asynchronously, no redirect after release.
REQ-031 Taken beq: ex_valid=1, br_type=0, br_taken=1, br_target=0x100, mem_busy=0 at cycle N -> flush_ex=1 at N and N+1, pc_sel=1 and pc_target=0x100 at N+1 only.
REQ-032 Not taken: br_type=1, br_taken=0 for 5 cycles -> pc_sel=0, flush_ex=0 throughout; br_cnt=5, taken_cnt=0 (BR_STATS_EN).
REQ-033 Collision: take with br_target=0x200 while mem_busy=1 for 3 cycles -> stall=1 for 3 cycles, flush_ex=0, pc_sel=1 with 0x200 exactly one cycle after mem_busy falls.
REQ-034 Back-to-back: br_taken=1 held in N and N+1 with targets 0x100 then 0x300 -> only 0x100 redirected; br_type=3 never increments br_cnt.
REQ-035 Saturation: CNT_WIDTH=4, 20 taken conditional branches -> br_cnt=taken_cnt=15; macro undefined -> both 0.
